// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG entropy path: marker codes, stuffing bytes,
// unpacker FSM encoding and restart-marker classification.
package jpeg_pkg;

  localparam logic [7:0] MRK_RST0 = 8'hD0;
  localparam logic [7:0] MRK_RST7 = 8'hD7;
  localparam logic [7:0] MRK_EOI  = 8'hD9;
  localparam logic [7:0] BYTE_FF  = 8'hFF;
  localparam logic [7:0] BYTE_00  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_HALT
  } unpack_state_t;

  function automatic logic is_rst_marker(input logic [7:0] code);
    return (code >= MRK_RST0) && (code <= MRK_RST7);
  endfunction

endpackage

// File: rtl/jpeg_bitstream_unpacker.sv
// Entropy-coded-segment byte unpacker: removes FF00 stuffing, detects markers
// and serialises data bits MSB-first into the Huffman decoder.
module jpeg_bitstream_unpacker
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       bit_out,
  output logic       bit_valid,
  input  logic       bit_ready,
  output logic [7:0] marker_code,
  output logic       marker_valid,
  output logic       bad_marker,
  output logic       halted
);

  unpack_state_t state, state_nx;

  logic [7:0] cur_sr, cur_nx;
  logic [3:0] bits_left, bits_nx;
  logic [7:0] nxt_byte, nxt_nx;
  logic       nxt_valid, nxt_valid_nx;
  logic       ff_pending, ff_nx;
  logic [7:0] code_q, code_nx;
  logic       mv_q, mv_nx;
  logic       bad_q, bad_nx;
  logic       halted_q, halted_nx;

  logic       consume, cur_free, accept, pipe_empty;
  logic       wr_data;
  logic [7:0] wr_byte;

  assign byte_ready   = (state == ST_RUN) && !nxt_valid && !start;
  assign bit_valid    = (bits_left != 4'd0);
  assign bit_out      = cur_sr[7];
  assign marker_code  = code_q;
  assign marker_valid = mv_q;
  assign bad_marker   = bad_q;
  assign halted       = halted_q;

  assign consume    = bit_valid && bit_ready;
  assign cur_free   = (bits_left == 4'd0) || ((bits_left == 4'd1) && consume);
  assign accept     = byte_valid && byte_ready;
  assign pipe_empty = (bits_left == 4'd0) && !nxt_valid;

  always_comb begin
    state_nx     = state;
    cur_nx       = cur_sr;
    bits_nx      = bits_left;
    nxt_nx       = nxt_byte;
    nxt_valid_nx = nxt_valid;
    ff_nx        = ff_pending;
    code_nx      = code_q;
    mv_nx        = 1'b0;
    bad_nx       = 1'b0;
    halted_nx    = (state == ST_HALT);
    wr_data      = 1'b0;
    wr_byte      = byte_in;

    if (accept) begin
      if (ff_pending) begin
        if (byte_in == BYTE_00) begin
          wr_data = 1'b1;
          wr_byte = BYTE_FF;
          ff_nx   = 1'b0;
        end else if (byte_in != BYTE_FF) begin
          code_nx  = byte_in;
          ff_nx    = 1'b0;
          state_nx = ST_DRAIN;
        end
      end else if (byte_in == BYTE_FF) begin
        ff_nx = 1'b1;
      end else begin
        wr_data = 1'b1;
      end
    end

    // A byte accepted while cur empties bypasses nxt so the first bit is
    // visible the next cycle; accept implies nxt is empty.
    if (cur_free && nxt_valid) begin
      cur_nx       = nxt_byte;
      bits_nx      = 4'd8;
      nxt_valid_nx = 1'b0;
    end else if (cur_free && wr_data) begin
      cur_nx  = wr_byte;
      bits_nx = 4'd8;
    end else if (consume) begin
      cur_nx  = {cur_sr[6:0], 1'b0};
      bits_nx = bits_left - 4'd1;
    end

    if (wr_data && !cur_free) begin
      nxt_nx       = wr_byte;
      nxt_valid_nx = 1'b1;
    end

    if ((state == ST_DRAIN) && pipe_empty) begin
      mv_nx    = 1'b1;
      bad_nx   = !is_rst_marker(code_q) && (code_q != MRK_EOI);
      state_nx = is_rst_marker(code_q) ? ST_RUN : ST_HALT;
    end

    if (start) begin
      state_nx     = ST_RUN;
      cur_nx       = '0;
      bits_nx      = '0;
      nxt_nx       = '0;
      nxt_valid_nx = 1'b0;
      ff_nx        = 1'b0;
      code_nx      = '0;
      mv_nx        = 1'b0;
      bad_nx       = 1'b0;
      halted_nx    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_sr     <= '0;
      bits_left  <= '0;
      nxt_byte   <= '0;
      nxt_valid  <= 1'b0;
      ff_pending <= 1'b0;
      code_q     <= '0;
      mv_q       <= 1'b0;
      bad_q      <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state      <= state_nx;
      cur_sr     <= cur_nx;
      bits_left  <= bits_nx;
      nxt_byte   <= nxt_nx;
      nxt_valid  <= nxt_valid_nx;
      ff_pending <= ff_nx;
      code_q     <= code_nx;
      mv_q       <= mv_nx;
      bad_q      <= bad_nx;
      halted_q   <= halted_nx;
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
// Directed self-checking bench for jpeg_bitstream_unpacker: serialisation,
// stuffing removal, marker ordering, stalls, halt/restart and reset mid-byte.
module tb_jpeg_bitstream_unpacker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] byte_in = '0;
  logic       byte_valid = 1'b0;
  logic       byte_ready;
  logic       bit_out;
  logic       bit_valid;
  logic       bit_ready = 1'b1;
  logic [7:0] marker_code;
  logic       marker_valid;
  logic       bad_marker;
  logic       halted;

  jpeg_bitstream_unpacker dut (
    .clk(clk), .rst(rst), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .marker_code(marker_code), .marker_valid(marker_valid),
    .bad_marker(bad_marker), .halted(halted)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [7:0] src[$];
  logic       got[$];
  int         mrk_cnt, mrk_cycle, bits_at_mrk, first_valid, acc0, last_bit, hold_err;
  logic [7:0] mrk_code;
  logic       mrk_bad;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic [31:0] pack_bits();
    logic [31:0] v = '0;
    foreach (got[i]) v = {v[30:0], got[i]};
    return v;
  endfunction

  // Feeds src bytes for a fixed number of cycles, recording consumed bits,
  // marker events and whether stalled outputs stayed stable.
  task automatic pump(input int cycles, input bit toggle);
    int   idx = 0;
    logic prev_stall = 1'b0;
    logic prev_b = 1'b0;
    got.delete();
    mrk_cnt = 0; mrk_cycle = -1; bits_at_mrk = -1; first_valid = -1;
    acc0 = -1; last_bit = -1; hold_err = 0; mrk_code = '0; mrk_bad = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      if (marker_valid) begin
        mrk_cnt++; mrk_cycle = c; mrk_code = marker_code;
        mrk_bad = bad_marker; bits_at_mrk = got.size();
      end
      if (prev_stall && (bit_valid !== 1'b1 || bit_out !== prev_b)) hold_err++;
      bit_ready = toggle ? (c % 2 == 0) : 1'b1;
      if (idx < src.size()) begin
        byte_valid = 1'b1;
        byte_in    = src[idx];
      end else begin
        byte_valid = 1'b0;
      end
      #1;
      if (byte_valid && byte_ready) begin
        if (idx == 0) acc0 = c;
        idx++;
      end
      if (bit_valid && first_valid < 0) first_valid = c;
      if (bit_valid && bit_ready) begin
        got.push_back(bit_out);
        last_bit = c;
      end
      prev_stall = bit_valid && !bit_ready;
      prev_b     = bit_out;
      step();
    end
    byte_valid = 1'b0;
    bit_ready  = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; byte_valid = 1'b1; byte_in = 8'hA5;
    step(); step();
    total++; if (bit_valid !== 1'b0) $display("FAIL reset_bit_valid got %b want 0", bit_valid); else passed++;
    total++; if (bit_out !== 1'b0) $display("FAIL reset_bit_out got %b want 0", bit_out); else passed++;
    total++; if (byte_ready !== 1'b0) $display("FAIL reset_byte_ready got %b want 0", byte_ready); else passed++;
    total++; if ({marker_valid, bad_marker, halted} !== 3'b000)
      $display("FAIL reset_flags got %b want 000", {marker_valid, bad_marker, halted}); else passed++;
    total++; if (marker_code !== 8'h00) $display("FAIL reset_marker_code got %h want 00", marker_code); else passed++;
    rst = 1'b0;
    step();
    total++; if (byte_ready !== 1'b0) $display("FAIL idle_byte_ready got %b want 0", byte_ready); else passed++;
    byte_valid = 1'b0;
  endtask

  task automatic test_basic();
    pulse_start();
    src = '{8'hA5, 8'h3C};
    pump(24, 1'b0);
    total++; if (got.size() !== 16) $display("FAIL basic_count got %0d want 16", got.size()); else passed++;
    total++; if (pack_bits() !== 32'h0000A53C) $display("FAIL basic_bits got %h want a53c", pack_bits()); else passed++;
    total++; if (first_valid - acc0 !== 1) $display("FAIL basic_latency got %0d want 1", first_valid - acc0); else passed++;
    total++; if (last_bit - first_valid !== 15) $display("FAIL basic_back_to_back got %0d want 15", last_bit - first_valid); else passed++;
  endtask

  task automatic test_stuffing();
    pulse_start();
    src = '{8'h12, 8'hFF, 8'h00, 8'h34};
    pump(40, 1'b0);
    total++; if (got.size() !== 24) $display("FAIL stuff_count got %0d want 24", got.size()); else passed++;
    total++; if (pack_bits() !== 32'h0012FF34) $display("FAIL stuff_bits got %h want 12ff34", pack_bits()); else passed++;
    total++; if (mrk_cnt !== 0) $display("FAIL stuff_no_marker got %0d want 0", mrk_cnt); else passed++;
  endtask

  task automatic test_rst_marker();
    pulse_start();
    src = '{8'h55, 8'hFF, 8'hD3, 8'h77};
    pump(40, 1'b0);
    total++; if (pack_bits() !== 32'h00005577 || got.size() !== 16)
      $display("FAIL rstm_bits got %h/%0d want 5577/16", pack_bits(), got.size()); else passed++;
    total++; if (mrk_cnt !== 1 || mrk_code !== 8'hD3)
      $display("FAIL rstm_marker got %0d x %h want 1 x d3", mrk_cnt, mrk_code); else passed++;
    total++; if (mrk_bad !== 1'b0) $display("FAIL rstm_bad got %b want 0", mrk_bad); else passed++;
    total++; if (bits_at_mrk !== 8) $display("FAIL rstm_order got %0d want 8", bits_at_mrk); else passed++;
    total++; if (halted !== 1'b0) $display("FAIL rstm_halted got %b want 0", halted); else passed++;
  endtask

  task automatic test_eoi_stall();
    pulse_start();
    src = '{8'h0F, 8'hFF, 8'hFF, 8'hD9};
    pump(40, 1'b1);
    total++; if (pack_bits() !== 32'h0000000F || got.size() !== 8)
      $display("FAIL eoi_bits got %h/%0d want 0f/8", pack_bits(), got.size()); else passed++;
    total++; if (hold_err !== 0) $display("FAIL eoi_hold got %0d want 0", hold_err); else passed++;
    total++; if (mrk_cnt !== 1 || mrk_code !== 8'hD9 || mrk_bad !== 1'b0)
      $display("FAIL eoi_marker got %0d x %h bad %b want 1 x d9 bad 0", mrk_cnt, mrk_code, mrk_bad); else passed++;
    total++; if (bits_at_mrk !== 8) $display("FAIL eoi_order got %0d want 8", bits_at_mrk); else passed++;
    byte_valid = 1'b1; byte_in = 8'h11;
    #1;
    total++; if (halted !== 1'b1) $display("FAIL eoi_halted got %b want 1", halted); else passed++;
    total++; if (byte_ready !== 1'b0) $display("FAIL eoi_byte_ready got %b want 0", byte_ready); else passed++;
    step();
    byte_valid = 1'b0;
  endtask

  task automatic test_bad_marker();
    pulse_start();
    src = '{8'hFF, 8'hC4};
    pump(20, 1'b0);
    total++; if (mrk_cnt !== 1 || mrk_code !== 8'hC4 || mrk_bad !== 1'b1)
      $display("FAIL bad_marker got %0d x %h bad %b want 1 x c4 bad 1", mrk_cnt, mrk_code, mrk_bad); else passed++;
    total++; if (got.size() !== 0) $display("FAIL bad_no_bits got %0d want 0", got.size()); else passed++;
    total++; if (halted !== 1'b1) $display("FAIL bad_halted got %b want 1", halted); else passed++;
    start = 1'b1; byte_valid = 1'b1; byte_in = 8'hAA;
    #1;
    total++; if (byte_ready !== 1'b0) $display("FAIL start_byte_ready got %b want 0", byte_ready); else passed++;
    step();
    start = 1'b0; byte_valid = 1'b0;
    #1;
    total++; if (byte_ready !== 1'b1) $display("FAIL start_run got %b want 1", byte_ready); else passed++;
    total++; if (bit_valid !== 1'b0) $display("FAIL start_empty got %b want 0", bit_valid); else passed++;
    total++; if (halted !== 1'b0 || marker_code !== 8'h00)
      $display("FAIL start_cleared got %b/%h want 0/00", halted, marker_code); else passed++;
    step();
  endtask

  task automatic test_reset_mid_byte();
    pulse_start();
    src = '{8'hC3};
    pump(4, 1'b0);
    total++; if (got.size() !== 3 || pack_bits() !== 32'h6)
      $display("FAIL mid_partial got %h/%0d want 6/3", pack_bits(), got.size()); else passed++;
    rst = 1'b1;
    step();
    total++; if (bit_valid !== 1'b0 || bit_out !== 1'b0)
      $display("FAIL mid_reset_bits got %b%b want 00", bit_valid, bit_out); else passed++;
    total++; if ({byte_ready, marker_valid, bad_marker, halted} !== 4'b0000)
      $display("FAIL mid_reset_flags got %b want 0000", {byte_ready, marker_valid, bad_marker, halted}); else passed++;
    rst = 1'b0;
    step();
    pulse_start();
    src = '{8'h5A};
    pump(12, 1'b0);
    total++; if (got.size() !== 8 || pack_bits() !== 32'h5A)
      $display("FAIL mid_restart got %h/%0d want 5a/8", pack_bits(), got.size()); else passed++;
    total++; if (mrk_cnt !== 0) $display("FAIL mid_no_marker got %0d want 0", mrk_cnt); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_stuffing();
    test_rst_marker();
    test_eoi_stall();
    test_bad_marker();
    test_reset_mid_byte();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
